// File: rtl/uart_pkg.sv
// Shared definitions for the UART APB register block: register offsets,
// IIR interrupt identification codes and the APB tracking state encoding.
package uart_pkg;

  localparam logic [7:0] OFS_RBR    = 8'h00;  // RBR on read, THR on write
  localparam logic [7:0] OFS_IER    = 8'h04;
  localparam logic [7:0] OFS_IIR    = 8'h08;  // IIR on read, FCR on write
  localparam logic [7:0] OFS_LCR    = 8'h0C;
  localparam logic [7:0] OFS_LSR    = 8'h14;
  localparam logic [7:0] OFS_DLL    = 8'h20;
  localparam logic [7:0] OFS_DLH    = 8'h24;
  localparam logic [7:0] OFS_PWREMU = 8'h30;

  localparam logic [2:0] IIR_NONE = 3'b000;
  localparam logic [2:0] IIR_LS   = 3'b011;
  localparam logic [2:0] IIR_RX   = 3'b010;
  localparam logic [2:0] IIR_THRE = 3'b001;

  typedef enum logic [1:0] {
    APB_IDLE,
    APB_SETUP,
    APB_ACCESS
  } apb_state_e;

endpackage

// File: rtl/uart_apb_wait_fsm.sv
// APB transfer tracker with programmable wait states.
//
// state      | meaning
// APB_IDLE   | no transfer in progress, waiting for a setup phase
// APB_SETUP  | setup phase seen, access starts next cycle
// APB_ACCESS | access phase, wait counter runs 0..WAIT_STATES, pready at the end
module uart_apb_wait_fsm
  import uart_pkg::*;
#(
  parameter int WAIT_STATES = 0
) (
  input  logic pclk,
  input  logic presetn,
  input  logic psel,
  input  logic penable,
  input  logic pwrite,
  output logic pready,
  output logic wr_done,
  output logic rd_done
);

  localparam logic [1:0] WS_LAST = 2'(WAIT_STATES);

  apb_state_e state_q, state_d;
  logic [1:0] cnt_q, cnt_d;

  // State and wait counter registers.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= APB_IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, wait counting and completion decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pready  = 1'b0;
    case (state_q)
      APB_IDLE: begin
        if (psel && !penable) state_d = APB_SETUP;
      end
      APB_SETUP: begin
        state_d = APB_ACCESS;
        cnt_d   = 2'd0;
      end
      APB_ACCESS: begin
        if (cnt_q == WS_LAST) begin
          pready  = 1'b1;
          state_d = (psel && !penable) ? APB_SETUP : APB_IDLE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      default: state_d = APB_IDLE;
    endcase
  end

  assign wr_done = pready & pwrite;
  assign rd_done = pready & ~pwrite;

endmodule

// File: rtl/uart_apb_csr.sv
// UART control/status register block on APB: address decode, configuration
// registers, line status sticky bits and interrupt identification.
module uart_apb_csr
  import uart_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 0,
  parameter int RX_TL_W     = 2
) (
  input  logic               pclk,
  input  logic               presetn,
  input  logic               psel,
  input  logic               penable,
  input  logic               pwrite,
  input  logic [ADDR_W-1:0]  paddr,
  input  logic [31:0]        pwdata,
  output logic [31:0]        prdata,
  output logic               pready,
  output logic               pslverr,
  input  logic [10:0]        rx_data,
  input  logic               rx_fifo_empty,
  input  logic               tx_fifo_empty,
  input  logic               tsr_empty,
  input  logic               rx_tl_hit,
  input  logic               rx_overrun,
  output logic               thr_wr_en,
  output logic               rbr_rd_en,
  output logic [7:0]         thr_data,
  output logic [7:0]         lcr,
  output logic [7:0]         dll,
  output logic [7:0]         dlh,
  output logic               fifoen,
  output logic [RX_TL_W-1:0] rxfiftl,
  output logic               rxclr,
  output logic               txclr,
  output logic               utrst,
  output logic               urrst,
  output logic               irq
);

  logic wr_done, rd_done;

  uart_apb_wait_fsm #(.WAIT_STATES(WAIT_STATES)) u_wait (
    .pclk    (pclk),
    .presetn (presetn),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .pready  (pready),
    .wr_done (wr_done),
    .rd_done (rd_done)
  );

  logic sel_rbr, sel_ier, sel_iir, sel_lcr, sel_lsr, sel_dll, sel_dlh, sel_pwr;
  logic mapped, err, wr, rd;

  assign sel_rbr = (paddr == ADDR_W'(OFS_RBR));
  assign sel_ier = (paddr == ADDR_W'(OFS_IER));
  assign sel_iir = (paddr == ADDR_W'(OFS_IIR));
  assign sel_lcr = (paddr == ADDR_W'(OFS_LCR));
  assign sel_lsr = (paddr == ADDR_W'(OFS_LSR));
  assign sel_dll = (paddr == ADDR_W'(OFS_DLL));
  assign sel_dlh = (paddr == ADDR_W'(OFS_DLH));
  assign sel_pwr = (paddr == ADDR_W'(OFS_PWREMU));
  assign mapped  = sel_rbr | sel_ier | sel_iir | sel_lcr | sel_lsr | sel_dll | sel_dlh | sel_pwr;

  // LSR is read-only; writing it is an error just like an unmapped address.
  assign err     = ~mapped | (pwrite & sel_lsr);
  assign pslverr = pready & err;
  assign wr      = wr_done & ~err;
  assign rd      = rd_done & ~err;

  logic [2:0] ier;
  logic       oe, pe, fe, bi;
  logic       thre_d, thre_pend;
  logic [7:0] lsr, iir;
  logic [2:0] iir_code;
  logic       int_pend;

  assign lsr = {|rx_data[10:8], tx_fifo_empty & tsr_empty, tx_fifo_empty,
                bi, fe, pe, oe, ~rx_fifo_empty};

  // Interrupt source priority: line status, then RX data, then THRE.
  always_comb begin
    iir_code = IIR_NONE;
    if (ier[2] && (|lsr[4:1]))                            iir_code = IIR_LS;
    else if (ier[0] && lsr[0] && (!fifoen || rx_tl_hit)) iir_code = IIR_RX;
    else if (ier[1] && thre_pend)                         iir_code = IIR_THRE;
  end

  assign int_pend = (iir_code != IIR_NONE);
  assign iir      = {fifoen, fifoen, 2'b00, iir_code, ~int_pend};

  // Read data mux, driven only during a good read completion.
  always_comb begin
    prdata = 32'd0;
    if (rd) begin
      if (sel_rbr)      prdata = {24'd0, rx_data[7:0]};
      else if (sel_ier) prdata = {29'd0, ier};
      else if (sel_iir) prdata = {24'd0, iir};
      else if (sel_lcr) prdata = {24'd0, lcr};
      else if (sel_lsr) prdata = {24'd0, lsr};
      else if (sel_dll) prdata = {24'd0, dll};
      else if (sel_dlh) prdata = {24'd0, dlh};
      else if (sel_pwr) prdata = {17'd0, utrst, urrst, 13'd0};
    end
  end

  assign thr_wr_en = wr & sel_rbr;
  assign thr_data  = pwdata[7:0];
  assign rbr_rd_en = rd & sel_rbr & ~rx_fifo_empty;
  assign rxclr     = wr & sel_iir & pwdata[1];
  assign txclr     = wr & sel_iir & pwdata[2];

  // Configuration registers, updated on write completion only.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      ier     <= 3'd0;
      fifoen  <= 1'b0;
      rxfiftl <= '0;
      lcr     <= 8'd0;
      dll     <= 8'd0;
      dlh     <= 8'd0;
      utrst   <= 1'b0;
      urrst   <= 1'b0;
    end else if (wr) begin
      if (sel_ier) ier <= pwdata[2:0];
      if (sel_iir) begin
        fifoen  <= pwdata[0];
        rxfiftl <= RX_TL_W'(pwdata[7:6]);
      end
      if (sel_lcr) lcr <= pwdata[7:0];
      if (sel_dll) dll <= pwdata[7:0];
      if (sel_dlh) dlh <= pwdata[7:0];
      if (sel_pwr) begin
        utrst <= pwdata[14];
        urrst <= pwdata[13];
      end
    end
  end

  logic lsr_clr, rbr_rd, thre_set, thre_clr;

  assign lsr_clr  = rd & sel_lsr;
  assign rbr_rd   = rd & sel_rbr;
  assign thre_set = (tx_fifo_empty & ~thre_d) | (wr & sel_ier & pwdata[1] & tx_fifo_empty);
  assign thre_clr = (wr & sel_rbr) | (rd & sel_iir & (iir_code == IIR_THRE));

  // Sticky line-status bits, THRE pending latch and registered irq.
  // A set event in the clearing cycle wins so no error is silently lost.
  // thre_d resets high so an already-empty TX path does not look like a fresh edge.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      oe        <= 1'b0;
      pe        <= 1'b0;
      fe        <= 1'b0;
      bi        <= 1'b0;
      thre_d    <= 1'b1;
      thre_pend <= 1'b0;
      irq       <= 1'b0;
    end else begin
      oe        <= rx_overrun | (oe & ~lsr_clr);
      pe        <= (rbr_rd & rx_data[8])  | (pe & ~lsr_clr);
      fe        <= (rbr_rd & rx_data[9])  | (fe & ~lsr_clr);
      bi        <= (rbr_rd & rx_data[10]) | (bi & ~lsr_clr);
      thre_d    <= tx_fifo_empty;
      thre_pend <= thre_set | (thre_pend & ~thre_clr);
      irq       <= int_pend;
    end
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, pwdata[31:15], pwdata[12:8]};

endmodule
